// File: rtl/prog_loader_pkg.sv
// Shared types, constants and helpers for the byte-serial program loader.
package prog_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned TIMEOUT_DEF   = 1000;
  localparam int unsigned TO_W_DEF      = 10;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned ADDR_W        = 8;
  localparam int unsigned CNT_W         = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } imem_wr_t;

  // A LEN byte of zero encodes a full 256-word image.
  function automatic logic [CNT_W-1:0] frame_words(input logic [BYTE_W-1:0] len);
    return (len == '0) ? CNT_W'(256) : CNT_W'(len);
  endfunction

  function automatic logic in_frame(input state_e s);
    return (s == ST_LEN) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, instruction-memory write port and CPU control out.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic                in_valid;
  logic [BYTE_W-1:0]   in_data;
  logic                in_ready;
  logic                imem_we;
  logic [ADDR_W-1:0]   imem_addr;
  logic [WORD_W-1:0]   imem_wdata;
  logic                cpu_run;
  logic                busy;
  logic                err;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_run, busy, err
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_run, busy, err
  );

endinterface

// File: rtl/prog_loader_idle_timer.sv
// Idle-cycle counter: cleared on demand, saturates at TIMEOUT and flags expiry.
module prog_loader_idle_timer #(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TO_W    = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TO_W-1:0] count_q, count_d;
  logic            expired_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != TO_W'(TIMEOUT))) begin
      count_d = count_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= (count_d == TO_W'(TIMEOUT));
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses SYNC/LEN/{HI,LO}xN/CHK frames into instruction memory,
// then releases the CPU once the checksum verifies.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned TO_W      = TO_W_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  prog_loader_if.slave  ldr
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [BYTE_W-1:0]  sum_q, sum_d;
  logic [BYTE_W-1:0]  hi_q, hi_d;
  imem_wr_t           wr_q, wr_d;
  logic               imem_we_q, imem_we_d;
  logic               in_ready_q, in_ready_d;
  logic               cpu_run_q, cpu_run_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               hs;
  logic               expired;
  logic [BYTE_W-1:0]  byte_in;

  assign hs      = ldr.in_valid & in_ready_q;
  assign byte_in = ldr.in_data;

  prog_loader_idle_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_idle_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (hs || !in_frame(state_q)),
    .en_i      (in_frame(state_q)),
    .expired_o (expired)
  );

  // Frame parser and registered output generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    sum_d     = sum_q;
    hi_d      = hi_q;
    wr_d      = wr_q;
    imem_we_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (hs && (byte_in == SYNC_BYTE)) begin
          state_d = ST_LEN;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_LEN: begin
        if (hs) begin
          n_d     = frame_words(byte_in);
          sum_d   = byte_in;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (hs) begin
          hi_d    = byte_in;
          sum_d   = sum_q + byte_in;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (hs) begin
          sum_d     = sum_q + byte_in;
          imem_we_d = 1'b1;
          wr_d.addr = cnt_q[ADDR_W-1:0];
          wr_d.data = {hi_q, byte_in};
          cnt_d     = cnt_q + CNT_W'(1);
          state_d   = (cnt_q == (n_q - CNT_W'(1))) ? ST_CHK : ST_HI;
        end
      end
      ST_CHK: begin
        if (hs) begin
          state_d = (byte_in == sum_q) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    // A stalled sender abandons the frame; a byte arriving the same cycle wins.
    if (!hs && expired && in_frame(state_q)) begin
      state_d = ST_ERR;
    end

    in_ready_d = (state_d != ST_DONE);
    busy_d     = in_frame(state_d);
    err_d      = (state_d == ST_ERR);
    cpu_run_d  = (state_q == ST_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      sum_q      <= '0;
      hi_q       <= '0;
      wr_q       <= '0;
      imem_we_q  <= 1'b0;
      in_ready_q <= 1'b1;
      cpu_run_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      sum_q      <= sum_d;
      hi_q       <= hi_d;
      wr_q       <= wr_d;
      imem_we_q  <= imem_we_d;
      in_ready_q <= in_ready_d;
      cpu_run_q  <= cpu_run_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign ldr.in_ready   = in_ready_q;
  assign ldr.imem_we    = imem_we_q;
  assign ldr.imem_addr  = wr_q.addr;
  assign ldr.imem_wdata = wr_q.data;
  assign ldr.cpu_run    = cpu_run_q;
  assign ldr.busy       = busy_q;
  assign ldr.err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad checksums, junk bytes, 256-word
// frames, idle timeout and mid-frame reset.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  prog_loader_if ldr();

  prog_loader dut (
    .clk_i (clk),
    .rst_i (rst),
    .ldr   (ldr)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [15:0] mem [256];
  int         wr_cnt = 0;
  logic [7:0] last_addr = 8'h00;
  int         base;
  int         cyc;
  int         nonzero;

  // Write capture: imem_we is a one-cycle pulse, so each negedge sees it once.
  always @(negedge clk) begin
    if (ldr.imem_we === 1'b1) begin
      mem[ldr.imem_addr] = ldr.imem_wdata;
      wr_cnt             = wr_cnt + 1;
      last_addr          = ldr.imem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ldr.in_valid = 1'b1;
    ldr.in_data  = b;
    @(posedge clk);
  endtask

  task automatic stop_send();
    @(negedge clk);
    ldr.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    ldr.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    ldr.in_valid = 1'b0;
    ldr.in_data  = 8'h00;

    // Reset state, sampled before the first clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(ldr.in_ready), 32'h1);
    check("rst_we",       32'(ldr.imem_we), 32'h0);
    check("rst_addr",     32'(ldr.imem_addr), 32'h0);
    check("rst_wdata",    32'(ldr.imem_wdata), 32'h0);
    check("rst_cpu_run",  32'(ldr.cpu_run), 32'h0);
    check("rst_busy",     32'(ldr.busy), 32'h0);
    check("rst_err",      32'(ldr.err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: good two-word frame; CHK = 02+12+34+56+78 mod 256 = 16.
    base = wr_cnt;
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34);
    stop_send();
    check("t1_we_pulse",  32'(ldr.imem_we), 32'h1);
    check("t1_addr0",     32'(ldr.imem_addr), 32'h0);
    check("t1_wdata0",    32'(ldr.imem_wdata), 32'h1234);
    check("t1_busy",      32'(ldr.busy), 32'h1);
    @(negedge clk);
    check("t1_we_single", 32'(ldr.imem_we), 32'h0);
    send(8'h56); send(8'h78); send(8'h16);
    stop_send();
    check("t1_writes",    32'(wr_cnt - base), 32'd2);
    check("t1_mem0",      32'(mem[0]), 32'h1234);
    check("t1_mem1",      32'(mem[1]), 32'h5678);
    check("t1_run_lag",   32'(ldr.cpu_run), 32'h0);
    check("t1_ready_off", 32'(ldr.in_ready), 32'h0);
    @(negedge clk);
    check("t1_cpu_run",   32'(ldr.cpu_run), 32'h1);
    check("t1_err",       32'(ldr.err), 32'h0);
    check("t1_busy_done", 32'(ldr.busy), 32'h0);

    // Test 2: wrong checksum, then a good frame recovers.
    do_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h17);
    stop_send();
    check("t2_writes",    32'(wr_cnt - base), 32'd2);
    check("t2_err",       32'(ldr.err), 32'h1);
    check("t2_ready",     32'(ldr.in_ready), 32'h1);
    check("t2_busy",      32'(ldr.busy), 32'h0);
    @(negedge clk);
    check("t2_cpu_run",   32'(ldr.cpu_run), 32'h0);
    send(8'hA5); send(8'h02);
    #1;
    check("t2_err_clear", 32'(ldr.err), 32'h0);
    check("t2_busy_again", 32'(ldr.busy), 32'h1);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h16);
    stop_send();
    @(negedge clk);
    check("t2_cpu_run_ok", 32'(ldr.cpu_run), 32'h1);
    check("t2_err_ok",     32'(ldr.err), 32'h0);

    // Test 3: junk before SYNC is dropped; CHK = 01+AB+CD mod 256 = 79.
    do_reset();
    base = wr_cnt;
    send(8'h00); send(8'hFF); send(8'h5A);
    stop_send();
    check("t3_no_write",  32'(wr_cnt - base), 32'd0);
    check("t3_idle_busy", 32'(ldr.busy), 32'h0);
    send(8'hA5); send(8'h01); send(8'hAB); send(8'hCD); send(8'h79);
    stop_send();
    @(negedge clk);
    check("t3_writes",    32'(wr_cnt - base), 32'd1);
    check("t3_mem0",      32'(mem[0]), 32'hABCD);
    check("t3_cpu_run",   32'(ldr.cpu_run), 32'h1);

    // Test 4: LEN=0 means 256 zero words back-to-back.
    do_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'h00); send(8'h00);
    end
    send(8'h00);
    stop_send();
    @(negedge clk);
    nonzero = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 16'h0000) nonzero = nonzero + 1;
    check("t4_writes",    32'(wr_cnt - base), 32'd256);
    check("t4_last_addr", 32'(last_addr), 32'hFF);
    check("t4_all_zero",  32'(nonzero), 32'd0);
    check("t4_cpu_run",   32'(ldr.cpu_run), 32'h1);

    // Test 5: stall after HI; ERR lands one edge after the timer reaches TIMEOUT.
    do_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h12);
    stop_send();
    cyc = 0;
    while (ldr.err !== 1'b1 && cyc < 1100) begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
    end
    check("t5_timeout_cyc", 32'(cyc), 32'd1001);
    check("t5_err",       32'(ldr.err), 32'h1);
    check("t5_no_write",  32'(wr_cnt - base), 32'd0);
    check("t5_cpu_run",   32'(ldr.cpu_run), 32'h0);
    check("t5_busy",      32'(ldr.busy), 32'h0);

    // Test 6: reset between HI and LO; CHK = 01+BE+EF mod 256 = AE.
    do_reset();
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h33);
    @(negedge clk);
    ldr.in_valid = 1'b0;
    rst          = 1'b1;
    #1;
    check("t6_busy",      32'(ldr.busy), 32'h0);
    check("t6_ready",     32'(ldr.in_ready), 32'h1);
    check("t6_addr",      32'(ldr.imem_addr), 32'h0);
    check("t6_wdata",     32'(ldr.imem_wdata), 32'h0);
    check("t6_we",        32'(ldr.imem_we), 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'hBE); send(8'hEF); send(8'hAE);
    stop_send();
    @(negedge clk);
    check("t6_writes",    32'(wr_cnt - base), 32'd1);
    check("t6_addr0",     32'(last_addr), 32'h0);
    check("t6_mem0",      32'(mem[0]), 32'hBEEF);
    check("t6_cpu_run",   32'(ldr.cpu_run), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
